// File: rtl/alarm_ringer.sv
// Alarm response FSM: rings on a rising alm_match edge, drives the LED_alm pattern,
// and handles snooze/stop buttons with ring-timeout and snooze-count limits.
module alarm_ringer #(
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_1hz,
    input  logic       alm_match,
    input  logic       alm_en,
    input  logic       button_snooze,
    input  logic       button_stop,
    output logic [3:0] LED_alm,
    output logic       ringing,
    output logic       snoozing,
    output logic [3:0] snooze_left
);

    localparam int RW = (RING_TIMEOUT_S > 2) ? $clog2(RING_TIMEOUT_S) : 1;
    localparam int SW = (SNOOZE_S > 2) ? $clog2(SNOOZE_S) : 1;

    localparam logic [RW-1:0] RING_LAST   = RW'(RING_TIMEOUT_S - 1);
    localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_S - 1);
    localparam logic [3:0]    SNZ_MAX     = 4'(MAX_SNOOZE);

    localparam logic [3:0] LED_OFF    = 4'b0000;
    localparam logic [3:0] LED_RING_A = 4'b1001;
    localparam logic [3:0] LED_RING_B = 4'b0110;
    localparam logic [3:0] LED_SNOOZE = 4'b0001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      led_q, led_d;
    logic [RW-1:0]   ring_sec_q, ring_sec_d;
    logic [SW-1:0]   snooze_sec_q, snooze_sec_d;
    logic [3:0]      snooze_cnt_q, snooze_cnt_d;
    logic            ringing_q, ringing_d;
    logic            snoozing_q, snoozing_d;
    logic [3:0]      snooze_left_q, snooze_left_d;
    logic            match_prev_q, snooze_prev_q, stop_prev_q;

    logic match_edge, snooze_edge, stop_edge;
    logic go_idle;

    assign match_edge  = alm_match & ~match_prev_q;
    assign snooze_edge = button_snooze & ~snooze_prev_q;
    assign stop_edge   = button_stop & ~stop_prev_q;

    always_comb begin
        state_d      = state_q;
        led_d        = led_q;
        ring_sec_d   = ring_sec_q;
        snooze_sec_d = snooze_sec_q;
        snooze_cnt_d = snooze_cnt_q;
        go_idle      = 1'b0;

        case (state_q)
            IDLE: begin
                // A tick in the same cycle as the trigger is deliberately not counted.
                if (match_edge && alm_en) begin
                    state_d      = RING;
                    led_d        = LED_RING_A;
                    ring_sec_d   = '0;
                    snooze_sec_d = '0;
                    snooze_cnt_d = '0;
                end
            end
            RING: begin
                if (!alm_en || stop_edge) begin
                    go_idle = 1'b1;
                end else if (snooze_edge && (snooze_cnt_q < SNZ_MAX)) begin
                    state_d      = SNOOZE;
                    led_d        = LED_SNOOZE;
                    snooze_sec_d = '0;
                    snooze_cnt_d = snooze_cnt_q + 4'd1;
                end else if (tick_1hz) begin
                    if (ring_sec_q == RING_LAST) begin
                        go_idle = 1'b1;
                    end else begin
                        ring_sec_d = ring_sec_q + RW'(1);
                        led_d      = (led_q == LED_RING_A) ? LED_RING_B : LED_RING_A;
                    end
                end
            end
            SNOOZE: begin
                if (!alm_en || stop_edge) begin
                    go_idle = 1'b1;
                end else if (tick_1hz) begin
                    if (snooze_sec_q == SNOOZE_LAST) begin
                        state_d    = RING;
                        led_d      = LED_RING_A;
                        ring_sec_d = '0;
                    end else begin
                        snooze_sec_d = snooze_sec_q + SW'(1);
                    end
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (go_idle) begin
            state_d      = IDLE;
            led_d        = LED_OFF;
            ring_sec_d   = '0;
            snooze_sec_d = '0;
            snooze_cnt_d = '0;
        end

        ringing_d     = (state_d == RING);
        snoozing_d    = (state_d == SNOOZE);
        snooze_left_d = SNZ_MAX - snooze_cnt_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            led_q         <= LED_OFF;
            ring_sec_q    <= '0;
            snooze_sec_q  <= '0;
            snooze_cnt_q  <= '0;
            ringing_q     <= 1'b0;
            snoozing_q    <= 1'b0;
            snooze_left_q <= SNZ_MAX;
            // Levels already high when reset releases must not look like fresh edges.
            match_prev_q  <= 1'b1;
            snooze_prev_q <= 1'b1;
            stop_prev_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            led_q         <= led_d;
            ring_sec_q    <= ring_sec_d;
            snooze_sec_q  <= snooze_sec_d;
            snooze_cnt_q  <= snooze_cnt_d;
            ringing_q     <= ringing_d;
            snoozing_q    <= snoozing_d;
            snooze_left_q <= snooze_left_d;
            match_prev_q  <= alm_match;
            snooze_prev_q <= button_snooze;
            stop_prev_q   <= button_stop;
        end
    end

    assign LED_alm     = led_q;
    assign ringing     = ringing_q;
    assign snoozing    = snoozing_q;
    assign snooze_left = snooze_left_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// Table-driven bench for alarm_ringer: each vector drives one cycle and pushes the
// expected outputs to a scoreboard queue that is popped after the clock edge.
module tb_alarm_ringer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       alm_match = 1'b1;
    logic       alm_en = 1'b1;
    logic       button_snooze = 1'b0;
    logic       button_stop = 1'b0;
    logic [3:0] LED_alm;
    logic       ringing;
    logic       snoozing;
    logic [3:0] snooze_left;

    alarm_ringer #(
        .RING_TIMEOUT_S(5),
        .SNOOZE_S      (3),
        .MAX_SNOOZE    (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick_1hz     (tick_1hz),
        .alm_match    (alm_match),
        .alm_en       (alm_en),
        .button_snooze(button_snooze),
        .button_stop  (button_stop),
        .LED_alm      (LED_alm),
        .ringing      (ringing),
        .snoozing     (snoozing),
        .snooze_left  (snooze_left)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] led;
        logic       rg;
        logic       sz;
        logic [3:0] left;
    } exp_t;

    typedef struct packed {
        logic r, t, m, e, s, p;
        exp_t exp;
    } vec_t;

    localparam logic [3:0] A = 4'b1001;
    localparam logic [3:0] B = 4'b0110;
    localparam logic [3:0] S = 4'b0001;
    localparam logic [3:0] Z = 4'b0000;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step = 0;

    function automatic vec_t mk(input logic r, t, m, e, s, p,
                                input logic [3:0] led, input logic rg, sz,
                                input logic [3:0] left);
        vec_t v;
        v.r = r; v.t = t; v.m = m; v.e = e; v.s = s; v.p = p;
        v.exp.led = led; v.exp.rg = rg; v.exp.sz = sz; v.exp.left = left;
        return v;
    endfunction

    task automatic add(input logic r, t, m, e, s, p,
                       input logic [3:0] led, input logic rg, sz, input logic [3:0] left);
        vecs.push_back(mk(r, t, m, e, s, p, led, rg, sz, left));
    endtask

    task automatic apply(input vec_t v);
        exp_t got, want;
        @(negedge clk);
        reset_n = v.r; tick_1hz = v.t; alm_match = v.m;
        alm_en = v.e; button_snooze = v.s; button_stop = v.p;
        sb.push_back(v.exp);
        @(posedge clk);
        #1;
        got = '{LED_alm, ringing, snoozing, snooze_left};
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL step %0d: got led=%b ring=%b snz=%b left=%0d, expected led=%b ring=%b snz=%b left=%0d",
                     step, got.led, got.rg, got.sz, got.left, want.led, want.rg, want.sz, want.left);
        end else begin
            $display("step %0d ok: in r=%b t=%b m=%b e=%b s=%b p=%b -> led=%b ring=%b snz=%b left=%0d",
                     step, v.r, v.t, v.m, v.e, v.s, v.p, got.led, got.rg, got.sz, got.left);
        end
        step++;
    endtask

    initial begin
        int n1;
        //   r  t  m  e  s  p    led rg sz left
        // reset with match held high, then a clean trigger
        add(0, 0, 1, 1, 0, 0,   Z, 0, 0, 2);
        add(0, 0, 1, 1, 0, 0,   Z, 0, 0, 2);
        add(1, 0, 1, 1, 0, 0,   Z, 0, 0, 2);
        add(1, 0, 1, 1, 0, 0,   Z, 0, 0, 2);
        add(1, 0, 0, 1, 0, 0,   Z, 0, 0, 2);
        add(1, 0, 1, 1, 0, 0,   A, 1, 0, 2);
        // unattended ring: auto-stop on the 5th tick
        add(1, 1, 0, 1, 0, 0,   B, 1, 0, 2);
        add(1, 0, 0, 1, 0, 0,   B, 1, 0, 2);
        add(1, 1, 0, 1, 0, 0,   A, 1, 0, 2);
        add(1, 1, 0, 1, 0, 0,   B, 1, 0, 2);
        add(1, 1, 0, 1, 0, 0,   A, 1, 0, 2);
        add(1, 1, 0, 1, 0, 0,   Z, 0, 0, 2);
        // snooze cycle until the limit, then stop
        add(1, 0, 1, 1, 0, 0,   A, 1, 0, 2);
        add(1, 0, 1, 1, 1, 0,   S, 0, 1, 1);
        add(1, 1, 1, 1, 0, 0,   S, 0, 1, 1);
        add(1, 0, 1, 1, 1, 0,   S, 0, 1, 1);
        add(1, 1, 1, 1, 0, 0,   S, 0, 1, 1);
        add(1, 1, 1, 1, 0, 0,   A, 1, 0, 1);
        add(1, 0, 1, 1, 1, 0,   S, 0, 1, 0);
        add(1, 1, 1, 1, 0, 0,   S, 0, 1, 0);
        add(1, 1, 1, 1, 0, 0,   S, 0, 1, 0);
        add(1, 1, 1, 1, 0, 0,   A, 1, 0, 0);
        add(1, 0, 1, 1, 1, 0,   A, 1, 0, 0);
        add(1, 1, 1, 1, 0, 0,   B, 1, 0, 0);
        add(1, 0, 1, 1, 0, 1,   Z, 0, 0, 2);
        add(1, 0, 1, 1, 0, 0,   Z, 0, 0, 2);
        // stop and snooze edges together
        add(1, 0, 0, 1, 0, 0,   Z, 0, 0, 2);
        add(1, 0, 1, 1, 0, 0,   A, 1, 0, 2);
        add(1, 0, 1, 1, 1, 1,   Z, 0, 0, 2);
        n1 = vecs.size();
        // alm_en drop in SNOOZE, trigger ignored while disabled
        add(1, 0, 0, 1, 0, 0,   Z, 0, 0, 2);
        add(1, 0, 1, 1, 0, 0,   A, 1, 0, 2);
        add(1, 0, 1, 1, 1, 0,   S, 0, 1, 1);
        add(1, 0, 1, 0, 0, 0,   Z, 0, 0, 2);
        add(1, 0, 0, 0, 0, 0,   Z, 0, 0, 2);
        add(1, 0, 1, 0, 0, 0,   Z, 0, 0, 2);
        add(1, 0, 0, 1, 0, 0,   Z, 0, 0, 2);
        add(1, 0, 1, 1, 0, 0,   A, 1, 0, 2);
        // reset asserted mid-snooze, match still high on release
        add(1, 0, 1, 1, 1, 0,   S, 0, 1, 1);
        add(1, 1, 1, 1, 0, 0,   S, 0, 1, 1);
        add(0, 0, 1, 1, 0, 0,   Z, 0, 0, 2);
        add(1, 0, 1, 1, 0, 0,   Z, 0, 0, 2);
        // match re-edge in RING keeps ring_sec and LED phase
        add(1, 0, 0, 1, 0, 0,   Z, 0, 0, 2);
        add(1, 0, 1, 1, 0, 0,   A, 1, 0, 2);
        add(1, 1, 1, 1, 0, 0,   B, 1, 0, 2);
        add(1, 1, 1, 1, 0, 0,   A, 1, 0, 2);
        add(1, 0, 0, 1, 0, 0,   A, 1, 0, 2);
        add(1, 0, 1, 1, 0, 0,   A, 1, 0, 2);
        add(1, 1, 1, 1, 0, 0,   B, 1, 0, 2);
        add(1, 1, 1, 1, 0, 0,   A, 1, 0, 2);
        add(1, 1, 1, 1, 0, 0,   Z, 0, 0, 2);
        // timeout tick plus snooze edge: snooze wins
        add(1, 0, 0, 1, 0, 0,   Z, 0, 0, 2);
        add(1, 0, 1, 1, 0, 0,   A, 1, 0, 2);
        add(1, 1, 1, 1, 0, 0,   B, 1, 0, 2);
        add(1, 1, 1, 1, 0, 0,   A, 1, 0, 2);
        add(1, 1, 1, 1, 0, 0,   B, 1, 0, 2);
        add(1, 1, 1, 1, 0, 0,   A, 1, 0, 2);
        add(1, 1, 1, 1, 1, 0,   S, 0, 1, 1);
        add(1, 0, 1, 1, 0, 1,   Z, 0, 0, 2);

        for (int i = 0; i < n1; i++) apply(vecs[i]);

        // buttons held high after the combined stop: nothing more happens
        for (int i = 0; i < 10; i++) apply(mk(1, 0, 1, 1, 1, 1, Z, 0, 0, 2));

        for (int i = n1; i < vecs.size(); i++) apply(vecs[i]);

        // a match edge after everything still triggers a fresh ring with full snoozes
        apply(mk(1, 0, 0, 1, 0, 0, Z, 0, 0, 2));
        apply(mk(1, 0, 1, 1, 0, 0, A, 1, 0, 2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
